uart_periph: RTL and testbench

APB slave UART (8N1) on the MCU peripheral bus, sitting downstream of the APB master alongside the GPIO, FND and timer slaves on a spare PSEL slot. It serializes CPU-written bytes onto `tx` through a 4-entry TX FIFO and deserializes `rx` into a 4-entry RX FIFO, using a 16x oversampling baud tick from a programmable divisor. It exposes status, data and divisor registers.

---
 rtl/uart_periph.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_uart_periph.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_periph.sv
// APB-attached 8N1 UART: 4-entry TX/RX FIFOs, 16x oversampled baud tick from
// a programmable divisor, status/data/divisor registers with one APB wait state.
module uart_periph #(
    parameter int FIFO_DEPTH = 4,
    parameter int BAUD_RST   = 650
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    input  logic        rx,
    output logic        tx
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic logic fifo_full(input logic [AW:0] wp, input logic [AW:0] rp);
        return (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    endfunction

    logic [1:0]  addr;
    logic        acc_first, acc_done, wr_done, rd_done;
    logic        pready_q, rd_pop_q;
    logic [31:0] prdata_q, rdata_mux, usr;
    logic [15:0] baud_q, cnt_q;
    logic        tick, baud_wr;
    logic        ovr_q, ferr_q, ovr_set, ferr_set;
    logic        unused_bits;

    logic [AW:0] txf_wp_q, txf_rp_q, rxf_wp_q, rxf_rp_q;
    logic [7:0]  txf_mem_q [FIFO_DEPTH];
    logic [7:0]  rxf_mem_q [FIFO_DEPTH];
    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic        txf_push, txf_pop, rxf_push, rxf_pop, rx_push_req;
    logic [7:0]  tx_rdata, rx_rdata;

    tx_state_t   tx_state_q, tx_state_d;
    logic [3:0]  tx_sub_q, tx_sub_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d, tx_busy;

    rx_state_t   rx_state_q, rx_state_d;
    logic [3:0]  rx_sub_q, rx_sub_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_fall;

    assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16]};

    assign addr      = PADDR[3:2];
    assign acc_first = PSEL & PENABLE & ~pready_q;
    assign acc_done  = PSEL & PENABLE & pready_q;
    assign wr_done   = acc_done & PWRITE;
    assign rd_done   = acc_done & ~PWRITE;
    assign baud_wr   = wr_done & (addr == 2'd2);

    assign PREADY = pready_q;
    assign PRDATA = prdata_q;
    assign tx     = tx_q;

    // FIFO status and handshakes
    assign tx_empty = (txf_wp_q == txf_rp_q);
    assign tx_full  = fifo_full(txf_wp_q, txf_rp_q);
    assign rx_empty = (rxf_wp_q == rxf_rp_q);
    assign rx_full  = fifo_full(rxf_wp_q, rxf_rp_q);
    assign tx_rdata = txf_mem_q[txf_rp_q[AW-1:0]];
    assign rx_rdata = rxf_mem_q[rxf_rp_q[AW-1:0]];

    assign txf_push = wr_done & (addr == 2'd1) & (~tx_full | txf_pop);
    assign rxf_pop  = rd_done & (addr == 2'd1) & rd_pop_q & ~rx_empty;
    assign rxf_push = rx_push_req & (~rx_full | rxf_pop);
    assign ovr_set  = rx_push_req & rx_full & ~rxf_pop;

    assign tx_busy = (tx_state_q != TX_IDLE) | ~tx_empty;
    assign usr     = {27'd0, tx_busy, ferr_q, ovr_q, ~tx_full, ~rx_empty};

    always_comb begin
        rdata_mux = '0;
        case (addr)
            2'd0:    rdata_mux = usr;
            2'd1:    rdata_mux = rx_empty ? 32'd0 : {24'd0, rx_rdata};
            2'd2:    rdata_mux = {16'd0, baud_q};
            default: rdata_mux = '0;
        endcase
    end

    // APB: data is captured in the first access cycle so it is valid with PREADY
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pready_q <= 1'b0;
            prdata_q <= '0;
            rd_pop_q <= 1'b0;
        end else begin
            pready_q <= acc_first;
            if (acc_first && !PWRITE) begin
                prdata_q <= rdata_mux;
                rd_pop_q <= (addr == 2'd1) & ~rx_empty;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            baud_q <= 16'(BAUD_RST);
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (baud_wr)
                baud_q <= PWDATA[15:0];
            ovr_q  <= ovr_set  | (ovr_q  & ~(wr_done & (addr == 2'd0) & PWDATA[2]));
            ferr_q <= ferr_set | (ferr_q & ~(wr_done & (addr == 2'd0) & PWDATA[3]));
        end
    end

    assign tick = (cnt_q == baud_q);

    always_ff @(posedge PCLK) begin
        if (PRESET || baud_wr || tick)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 16'd1;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            txf_wp_q <= '0;
            txf_rp_q <= '0;
            rxf_wp_q <= '0;
            rxf_rp_q <= '0;
        end else begin
            if (txf_push) txf_wp_q <= txf_wp_q + 1'b1;
            if (txf_pop)  txf_rp_q <= txf_rp_q + 1'b1;
            if (rxf_push) rxf_wp_q <= rxf_wp_q + 1'b1;
            if (rxf_pop)  rxf_rp_q <= rxf_rp_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (txf_push) txf_mem_q[txf_wp_q[AW-1:0]] <= PWDATA[7:0];
        if (rxf_push) rxf_mem_q[rxf_wp_q[AW-1:0]] <= rx_shift_q;
    end

    // TX: every bit lasts 16 ticks; STOP chains straight into START when data waits
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tx_state_q <= TX_IDLE;
            tx_sub_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_sub_q   <= tx_sub_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
        end
    end

    always_ff @(posedge PCLK) tx_shift_q <= tx_shift_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_sub_d   = tx_sub_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        txf_pop    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (tick && !tx_empty) begin
                    txf_pop    = 1'b1;
                    tx_shift_d = tx_rdata;
                    tx_sub_d   = '0;
                    tx_d       = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: if (tick) begin
                if (tx_sub_q == 4'd15) begin
                    tx_sub_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                end else
                    tx_sub_d = tx_sub_q + 4'd1;
            end
            TX_DATA: if (tick) begin
                if (tx_sub_q == 4'd15) begin
                    tx_sub_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else
                    tx_sub_d = tx_sub_q + 4'd1;
            end
            TX_STOP: if (tick) begin
                if (tx_sub_q == 4'd15) begin
                    tx_sub_d = '0;
                    if (!tx_empty) begin
                        txf_pop    = 1'b1;
                        tx_shift_d = tx_rdata;
                        tx_d       = 1'b0;
                        tx_state_d = TX_START;
                    end else begin
                        tx_d       = 1'b1;
                        tx_state_d = TX_IDLE;
                    end
                end else
                    tx_sub_d = tx_sub_q + 4'd1;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // RX: 2-FF synchronizer, then sample mid-bit (8 ticks into start, every 16 after)
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_sub_q   <= '0;
            rx_bit_q   <= '0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_sub_q   <= rx_sub_d;
            rx_bit_q   <= rx_bit_d;
        end
    end

    always_ff @(posedge PCLK) rx_shift_q <= rx_shift_d;

    assign rx_fall = rx_prev_q & ~rx_s2_q;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_sub_d    = rx_sub_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push_req = 1'b0;
        ferr_set    = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (rx_fall) begin
                rx_sub_d   = '0;
                rx_state_d = RX_START;
            end
            RX_START: if (tick) begin
                if (rx_sub_q == 4'd7) begin
                    rx_sub_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else
                    rx_sub_d = rx_sub_q + 4'd1;
            end
            RX_DATA: if (tick) begin
                if (rx_sub_q == 4'd15) begin
                    rx_sub_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7)
                        rx_state_d = RX_STOP;
                    else
                        rx_bit_d = rx_bit_q + 3'd1;
                end else
                    rx_sub_d = rx_sub_q + 4'd1;
            end
            RX_STOP: if (tick) begin
                if (rx_sub_q == 4'd15) begin
                    rx_sub_d    = '0;
                    rx_state_d  = RX_IDLE;
                    rx_push_req = rx_s2_q;
                    ferr_set    = ~rx_s2_q;
                end else
                    rx_sub_d = rx_sub_q + 4'd1;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_periph.sv
// Scoreboarded bench for uart_periph: APB reads and decoded tx frames are
// compared against queued expectations by independent monitors.
module tb_uart_periph;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [31:0] PADDR, PWDATA;
    logic        PWRITE, PENABLE, PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        tx, rx, rx_drv, loop;

    assign rx = loop ? tx : rx_drv;

    uart_periph #(.FIFO_DEPTH(4), .BAUD_RST(650)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA),
        .PREADY(PREADY), .rx(rx), .tx(tx)
    );

    always #5 PCLK = ~PCLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rst_epoch = 0;

    string       nameq[$];
    logic [31:0] expq[$];
    bit          chkq[$];
    logic [7:0]  txq[$];
    int          tx_starts[$];

    always @(posedge PCLK) begin
        cyc <= cyc + 1;
        if (PRESET) rst_epoch <= rst_epoch + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // APB read monitor
    always @(negedge PCLK) begin
        if (PSEL && PENABLE && PREADY && !PWRITE) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL apb_unexpected: got 0x%0h with nothing expected", PRDATA);
            end else begin
                string       n;
                logic [31:0] e;
                bit          c;
                n = nameq.pop_front();
                e = expq.pop_front();
                c = chkq.pop_front();
                if (c) begin
                    checks++;
                    if (PRDATA !== e) begin
                        errors++;
                        $display("FAIL %s: got 0x%0h expected 0x%0h", n, PRDATA, e);
                    end
                end
            end
        end
    end

    // tx frame monitor (16 cycles per bit, i.e. BAUD = 0)
    initial begin
        logic [9:0] fr;
        logic [7:0] e;
        int         ep, st;
        forever begin
            @(negedge PCLK);
            if (!PRESET && tx === 1'b0) begin
                ep = rst_epoch;
                st = cyc;
                repeat (7) @(negedge PCLK);
                fr[0] = tx;
                for (int i = 1; i < 10; i++) begin
                    repeat (16) @(negedge PCLK);
                    fr[i] = tx;
                end
                if (ep == rst_epoch) begin
                    tx_starts.push_back(st);
                    checks++;
                    if (txq.size() == 0) begin
                        errors++;
                        $display("FAIL tx_frame: got frame 0x%0h with nothing expected", fr);
                    end else begin
                        e = txq.pop_front();
                        if (fr !== {1'b1, e, 1'b0}) begin
                            errors++;
                            $display("FAIL tx_frame: got 0x%0h expected 0x%0h", fr, {1'b1, e, 1'b0});
                        end
                    end
                end
            end
        end
    end

    task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd);
        int n;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        n = 0;
        @(negedge PCLK);
        while (!PREADY && n < 8) begin
            @(negedge PCLK);
            n++;
        end
        check("apb_pready", {31'd0, PREADY}, 32'd1);
        rd = PRDATA;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        apb_xfer(1'b1, a, d, dummy);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] e);
        logic [31:0] dummy;
        nameq.push_back(name); expq.push_back(e); chkq.push_back(1'b1);
        apb_xfer(1'b0, a, 32'd0, dummy);
    endtask

    task automatic rd_poll(input logic [31:0] a, output logic [31:0] v);
        nameq.push_back("poll"); expq.push_back(32'd0); chkq.push_back(1'b0);
        apb_xfer(1'b0, a, 32'd0, v);
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] v;
        int n;
        n = 0;
        do begin
            rd_poll(32'h0, v);
            n++;
        end while (v[4] && n < 600);
        check(name, {31'd0, v[4]}, 32'd0);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(posedge PCLK); #1;
        rx_drv = 1'b0;
        repeat (16) @(posedge PCLK);
        for (int i = 0; i < 8; i++) begin
            #1 rx_drv = b[i];
            repeat (16) @(posedge PCLK);
        end
        #1 rx_drv = stop;
        repeat (16) @(posedge PCLK);
        #1 rx_drv = 1'b1;
        repeat (4) @(posedge PCLK);
    endtask

    initial begin
        PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        PRESET = 1'b1; rx_drv = 1'b1; loop = 1'b0;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_pready", {31'd0, PREADY}, 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        rd_chk("rst_usr", 32'h0, 32'h02);
        rd_chk("rst_baud", 32'h8, 32'd650);
        rd_chk("reg3", 32'hC, 32'd0);

        wr(32'h8, 32'd0);
        rd_chk("baud0", 32'h8, 32'd0);

        // single frame 0x55
        txq.push_back(8'h55);
        wr(32'h4, 32'h55);
        rd_chk("usr_busy", 32'h0, 32'h12);
        repeat (200) @(posedge PCLK);
        rd_chk("usr_idle", 32'h0, 32'h02);

        // loopback, back-to-back frames
        tx_starts.delete();
        loop = 1'b1;
        txq.push_back(8'hA5); txq.push_back(8'h3C);
        wr(32'h4, 32'hA5);
        wr(32'h4, 32'h3C);
        wait_idle("lb_idle");
        repeat (20) @(posedge PCLK);
        check("lb_frames", tx_starts.size(), 32'd2);
        if (tx_starts.size() == 2)
            check("lb_gap", tx_starts[1] - tx_starts[0], 32'd160);
        rd_chk("lb_rx0", 32'h4, 32'hA5);
        rd_chk("lb_rx1", 32'h4, 32'h3C);
        rd_chk("lb_usr", 32'h0, 32'h02);
        loop = 1'b0;

        // TX FIFO overflow while the line is busy
        txq.push_back(8'hFF);
        wr(32'h4, 32'hFF);
        repeat (4) @(posedge PCLK);
        for (int i = 1; i <= 4; i++) begin
            txq.push_back(8'(i));
            wr(32'h4, i);
        end
        rd_chk("usr_txfull", 32'h0, 32'h10);
        wr(32'h4, 32'h05);
        rd_chk("usr_txfull2", 32'h0, 32'h10);
        wait_idle("fill_idle");
        repeat (20) @(posedge PCLK);
        check("tx_frames_left", txq.size(), 32'd0);
        rd_chk("usr_after_fill", 32'h0, 32'h02);

        // RX overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        send_rx(8'h33, 1'b1);
        send_rx(8'h44, 1'b1);
        send_rx(8'h55, 1'b1);
        repeat (20) @(posedge PCLK);
        rd_chk("usr_ovr", 32'h0, 32'h07);
        rd_chk("rx_b0", 32'h4, 32'h11);
        rd_chk("rx_b1", 32'h4, 32'h22);
        rd_chk("rx_b2", 32'h4, 32'h33);
        rd_chk("rx_b3", 32'h4, 32'h44);
        rd_chk("rx_empty_rd", 32'h4, 32'h00);
        rd_chk("usr_ovr_empty", 32'h0, 32'h06);
        wr(32'h0, 32'h04);
        rd_chk("usr_ovr_clr", 32'h0, 32'h02);

        // short glitch
        @(posedge PCLK); #1 rx_drv = 1'b0;
        repeat (4) @(posedge PCLK);
        #1 rx_drv = 1'b1;
        repeat (60) @(posedge PCLK);
        rd_chk("usr_glitch", 32'h0, 32'h02);

        // framing error
        send_rx(8'h5A, 1'b0);
        repeat (20) @(posedge PCLK);
        rd_chk("usr_ferr", 32'h0, 32'h0A);
        wr(32'h0, 32'h08);
        rd_chk("usr_ferr_clr", 32'h0, 32'h02);

        // reset in the middle of a frame
        wr(32'h4, 32'h00);
        repeat (40) @(posedge PCLK);
        @(negedge PCLK);
        check("tx_midframe", {31'd0, tx}, 32'd0);
        @(posedge PCLK); #1 PRESET = 1'b1;
        @(posedge PCLK); #1;
        check("tx_after_rst", {31'd0, tx}, 32'd1);
        PRESET = 1'b0;
        txq.delete();
        rd_chk("usr_after_rst", 32'h0, 32'h02);
        rd_chk("baud_after_rst", 32'h8, 32'd650);
        repeat (200) @(posedge PCLK);
        check("apb_queue_empty", expq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
